// File: rtl/id_stage.sv
// RV32I decode stage: register file with write bypass, instruction decode,
// load-use interlock and a registered decoded-instruction output.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  output logic        in_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [4:0]  optype,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] immediate,
  output logic [31:0] offset,
  output logic [31:0] ins_addr,
  output logic [4:0]  rd
);

  localparam logic [4:0] OP_LUI = 5'd1, OP_AUIPC = 5'd2, OP_JAL = 5'd3, OP_JALR = 5'd4;
  localparam logic [4:0] OP_BEQ = 5'd5, OP_LB = 5'd11, OP_LHU = 5'd15, OP_SB = 5'd16;
  localparam logic [4:0] OP_ADD = 5'd19, OP_SUB = 5'd20, OP_SLL = 5'd21, OP_SLT = 5'd22;
  localparam logic [4:0] OP_SLTU = 5'd23, OP_XOR = 5'd24, OP_SRL = 5'd25, OP_SRA = 5'd26;
  localparam logic [4:0] OP_OR = 5'd27, OP_AND = 5'd28, OP_SYS = 5'd29, OP_ILL = 5'd31;

  logic [31:0] rf [32];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rdf;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rdf = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Register read with same-cycle bypass of the write port; x0 is hardwired zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : rf[rs1];
    if (rs2 != 5'd0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : rf[rs2];
  end

  logic [4:0]  d_op, d_rd;
  logic [31:0] d_d1, d_d2, d_imm, d_off;
  logic        use_rs1, use_rs2;

  // Decode the presented instruction into optype, operands and immediates.
  always_comb begin
    d_op = OP_ILL; d_rd = '0; d_d1 = '0; d_d2 = '0; d_imm = '0; d_off = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0;
    case (opc)
      7'b0110111: begin d_op = OP_LUI;   d_rd = rdf; d_imm = imm_u; end
      7'b0010111: begin d_op = OP_AUIPC; d_rd = rdf; d_imm = imm_u; end
      7'b1101111: begin d_op = OP_JAL;   d_rd = rdf; d_off = imm_j; end
      7'b1100111: if (f3 == 3'b000) begin
        d_op = OP_JALR; d_rd = rdf; d_imm = imm_i; d_off = imm_i;
        d_d1 = rs1_val; d_d2 = imm_i; use_rs1 = 1'b1;
      end
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
        // BEQ BNE _ _ BLT BGE BLTU BGEU -> 5..10
        d_op = (f3[2]) ? (OP_BEQ + 5'd2 + {3'b0, f3[1:0]}) : (OP_BEQ + {4'b0, f3[0]});
        d_off = imm_b; d_d1 = rs1_val; d_d2 = rs2_val;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0000011: if (f3 != 3'b011 && f3 < 3'b110) begin
        // LB LH LW _ LBU LHU -> 11..15
        d_op = (f3[2]) ? (OP_LB + 5'd3 + {4'b0, f3[0]}) : (OP_LB + {3'b0, f3[1:0]});
        d_rd = rdf; d_imm = imm_i; d_d1 = rs1_val; d_d2 = imm_i; use_rs1 = 1'b1;
      end
      7'b0100011: if (f3 < 3'b011) begin
        // Store: data1 carries the value to store, data2 the base address.
        d_op = OP_SB + {3'b0, f3[1:0]};
        d_imm = imm_s; d_d1 = rs2_val; d_d2 = rs1_val;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0010011: begin
        d_rd = rdf; d_imm = imm_i; use_rs1 = 1'b1;
        case (f3)
          3'b000: d_op = OP_ADD;
          3'b010: d_op = OP_SLT;
          3'b011: d_op = OP_SLTU;
          3'b100: d_op = OP_XOR;
          3'b110: d_op = OP_OR;
          3'b111: d_op = OP_AND;
          3'b001: d_op = (f7 == 7'b0000000) ? OP_SLL : OP_ILL;
          default: d_op = (f7 == 7'b0000000) ? OP_SRL : (f7 == 7'b0100000) ? OP_SRA : OP_ILL;
        endcase
        if (f3 == 3'b001 || f3 == 3'b101) d_imm = {27'b0, instr[24:20]};
        if (d_op == OP_ILL) begin d_rd = '0; d_imm = '0; use_rs1 = 1'b0; end
        else begin d_d1 = rs1_val; d_d2 = d_imm; end
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: d_op = OP_ADD;
            3'b001: d_op = OP_SLL;
            3'b010: d_op = OP_SLT;
            3'b011: d_op = OP_SLTU;
            3'b100: d_op = OP_XOR;
            3'b101: d_op = OP_SRL;
            3'b110: d_op = OP_OR;
            default: d_op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) d_op = OP_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) d_op = OP_SRA;
        if (d_op != OP_ILL) begin
          d_rd = rdf; d_d1 = rs1_val; d_d2 = rs2_val;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
      end
      7'b0001111, 7'b1110011: d_op = OP_SYS;
      default: d_op = OP_ILL;
    endcase
  end

  logic out_is_load, stall;

  // Load-use interlock against the load currently held in the output register.
  always_comb begin
    out_is_load = out_valid && (optype >= OP_LB) && (optype <= OP_LHU) && (rd != 5'd0);
    stall = in_valid && out_is_load &&
            ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
    in_ready = flush || !stall;
  end

  // Register file write port; keeps writing through flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Output register: reset > flush > stall/no input (bubble) > issue.
  always_ff @(posedge clk) begin
    if (rst || flush || !in_valid || stall) begin
      out_valid <= 1'b0; optype <= '0; data1 <= '0; data2 <= '0;
      immediate <= '0; offset <= '0; ins_addr <= '0; rd <= '0;
    end else begin
      out_valid <= 1'b1; optype <= d_op; data1 <= d_d1; data2 <= d_d2;
      immediate <= d_imm; offset <= d_off; ins_addr <= pc_in; rd <= d_rd;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table plus hand-written interlock/flush/reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, wb_en, out_valid;
  logic [31:0] instr, pc_in, wb_data, data1, data2, immediate, offset, ins_addr;
  logic [4:0]  wb_rd, optype, rd;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc_in(pc_in),
    .in_ready(in_ready), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .optype(optype), .data1(data1), .data2(data2),
    .immediate(immediate), .offset(offset), .ins_addr(ins_addr), .rd(rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  op;
    logic [31:0] d1, d2, imm, off, addr;
    logic [4:0]  rd;
  } out_t;

  typedef struct packed {
    logic        iv;
    logic [31:0] instr, pc;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    out_t        exp;
  } vec_t;

  localparam out_t BUB = '0;

  int   n_checks = 0, n_pass = 0;
  out_t sb_q[$];
  vec_t tbl[13];

  function automatic out_t mk(input logic [4:0] op, input logic [31:0] d1, d2, imm, off, addr,
                              input logic [4:0] r);
    out_t o;
    o.v = 1'b1; o.op = op; o.d1 = d1; o.d2 = d2; o.imm = imm; o.off = off; o.addr = addr; o.rd = r;
    return o;
  endfunction

  function automatic vec_t mv(input logic iv, input logic [31:0] ins, pc, input logic wbe,
                              input logic [4:0] wbr, input logic [31:0] wbd, input out_t e);
    vec_t t;
    t.iv = iv; t.instr = ins; t.pc = pc; t.wbe = wbe; t.wbr = wbr; t.wbd = wbd; t.exp = e;
    return t;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, pc, input logic fl);
    in_valid = iv; instr = ins; pc_in = pc; flush = fl;
  endtask

  task automatic check_ready(input string name, input logic exp);
    #1;
    n_checks++;
    if (in_ready === exp) n_pass++;
    else $display("FAIL %s: in_ready got %b want %b", name, in_ready, exp);
  endtask

  // Push the expected registered output, clock once, then pop and compare.
  task automatic step(input string name, input out_t exp);
    out_t act, want;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    act  = {out_valid, optype, data1, data2, immediate, offset, ins_addr, rd};
    want = sb_q.pop_front();
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got v=%b op=%0d d1=%h d2=%h imm=%h off=%h addr=%h rd=%0d want v=%b op=%0d d1=%h d2=%h imm=%h off=%h addr=%h rd=%0d",
                  name, act.v, act.op, act.d1, act.d2, act.imm, act.off, act.addr, act.rd,
                  want.v, want.op, want.d1, want.d2, want.imm, want.off, want.addr, want.rd);
    wb_en = 1'b0;
  endtask

  initial begin
    tbl[0]  = mv(0, 32'h0, 32'h0, 1, 5'd2, 32'h100, BUB);
    tbl[1]  = mv(0, 32'h0, 32'h0, 1, 5'd1, 32'h7, BUB);
    tbl[2]  = mv(1, 32'hFFB00093, 32'h10, 0, 5'd0, 32'h0,
                 mk(5'd19, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h0, 32'h10, 5'd1));
    tbl[3]  = mv(1, 32'h00318233, 32'h14, 1, 5'd3, 32'h1234,
                 mk(5'd19, 32'h1234, 32'h1234, 32'h0, 32'h0, 32'h14, 5'd4));
    tbl[4]  = mv(1, 32'h000003B3, 32'h18, 1, 5'd0, 32'hDEAD,
                 mk(5'd19, 32'h0, 32'h0, 32'h0, 32'h0, 32'h18, 5'd7));
    tbl[5]  = mv(1, 32'hFE000CE3, 32'h1C, 0, 5'd0, 32'h0,
                 mk(5'd5, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h1C, 5'd0));
    tbl[6]  = mv(1, 32'h001000EF, 32'h20, 0, 5'd0, 32'h0,
                 mk(5'd3, 32'h0, 32'h0, 32'h0, 32'h800, 32'h20, 5'd1));
    tbl[7]  = mv(1, 32'h0000007F, 32'h24, 0, 5'd0, 32'h0,
                 mk(5'd31, 32'h0, 32'h0, 32'h0, 32'h0, 32'h24, 5'd0));
    tbl[8]  = mv(1, 32'h00112423, 32'h28, 0, 5'd0, 32'h0,
                 mk(5'd18, 32'h7, 32'h100, 32'h8, 32'h0, 32'h28, 5'd0));
    tbl[9]  = mv(1, 32'h40415193, 32'h2C, 0, 5'd0, 32'h0,
                 mk(5'd26, 32'h100, 32'h4, 32'h4, 32'h0, 32'h2C, 5'd3));
    tbl[10] = mv(1, 32'h401102B3, 32'h30, 0, 5'd0, 32'h0,
                 mk(5'd20, 32'h100, 32'h7, 32'h0, 32'h0, 32'h30, 5'd5));
    tbl[11] = mv(1, 32'h123454B7, 32'h34, 0, 5'd0, 32'h0,
                 mk(5'd1, 32'h0, 32'h0, 32'h12345000, 32'h0, 32'h34, 5'd9));
    tbl[12] = mv(1, 32'hFFC100E7, 32'h38, 0, 5'd0, 32'h0,
                 mk(5'd4, 32'h100, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h38, 5'd1));

    rst = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1, 32'hFFB00093, 32'h10, 0);
    @(posedge clk);
    step("reset", BUB);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 0);
    check_ready("ready_after_reset", 1'b1);

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].instr, tbl[i].pc, 0);
      wb_en = tbl[i].wbe; wb_rd = tbl[i].wbr; wb_data = tbl[i].wbd;
      step($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Load-use: LW x5,0(x2) then ADD x6,x5,x1 stalls one cycle.
    drive(1, 32'h00012283, 32'h40, 0);
    step("lw_issue", mk(5'd13, 32'h100, 32'h0, 32'h0, 32'h0, 32'h40, 5'd5));
    drive(1, 32'h00128333, 32'h44, 0);
    check_ready("stall_ready", 1'b0);
    step("stall_bubble", BUB);
    check_ready("after_stall_ready", 1'b1);
    step("add_after_stall", mk(5'd19, 32'h0, 32'h7, 32'h0, 32'h0, 32'h44, 5'd6));

    // A load to x0 never interlocks.
    drive(1, 32'h00012003, 32'h48, 0);
    step("lw_x0", mk(5'd13, 32'h100, 32'h0, 32'h0, 32'h0, 32'h48, 5'd0));
    drive(1, 32'h00100333, 32'h4C, 0);
    check_ready("no_stall_x0", 1'b1);
    step("add_after_lw_x0", mk(5'd19, 32'h0, 32'h7, 32'h0, 32'h0, 32'h4C, 5'd6));

    // Flush while stalled: bubble, ready high, stalled ADD dropped.
    drive(1, 32'h00012283, 32'h50, 0);
    step("lw_issue2", mk(5'd13, 32'h100, 32'h0, 32'h0, 32'h0, 32'h50, 5'd5));
    drive(1, 32'h00128333, 32'h54, 0);
    check_ready("stall_ready2", 1'b0);
    flush = 1'b1;
    check_ready("flush_ready", 1'b1);
    step("flush_bubble", BUB);
    drive(0, 32'h0, 32'h0, 0);
    step("after_flush_bubble", BUB);

    // Flush discards a non-stalled instruction too.
    drive(1, 32'hFFB00093, 32'h58, 1);
    step("flush_discard", BUB);

    // Reset in the middle of a stall abandons it and clears the register file.
    drive(1, 32'h00012283, 32'h60, 0);
    step("lw_issue3", mk(5'd13, 32'h100, 32'h0, 32'h0, 32'h0, 32'h60, 5'd5));
    drive(1, 32'h00128333, 32'h64, 0);
    check_ready("stall_ready3", 1'b0);
    rst = 1'b1;
    step("reset_mid_stall", BUB);
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 0);
    check_ready("ready_after_reset2", 1'b1);
    step("post_reset_bubble", BUB);
    drive(1, 32'h00110433, 32'h68, 0);
    step("regs_cleared", mk(5'd19, 32'h0, 32'h0, 32'h0, 32'h0, 32'h68, 5'd8));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide in_valid  input  1  fetch presents an instruction.
REQ-004 SHALL provide instr  input  32  RV32I instruction word.
REQ-005 SHALL provide pc_in  input  32  address of instr.
REQ-006 SHALL provide in_ready  output  1  stage accepts instr this cycle; combinational.
REQ-007 SHALL provide flush  input  1  branch mispredict from execute; kill in-flight decode.
REQ-008 SHALL provide wb_en, wb_rd, wb_data  input  1/5/32  register-file write port.
REQ-009 SHALL provide out_valid  output  1  registered decoded instruction valid.
REQ-010 SHALL provide optype  output  5  operation code per REQ-015.
REQ-011 SHALL provide data1, data2  output  32 each  operand values per REQ-016.
REQ-012 SHALL provide immediate, offset, ins_addr  output  32 each  ALU/memory immediate, branch/jump offset, instruction address.
REQ-013 SHALL provide rd  output  5  destination register; 0 when none.

Function
REQ-014 SHALL contain a 32x32 register file; x0 reads 0, writes to x0 ignored.
REQ-015 SHALL encode optype: 0 NOP/bubble, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5-10 BEQ BNE BLT BGE BLTU BGEU, 11-15 LB LH LW LBU LHU, 16-18 SB SH SW, 19-28 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND (R- and I-type share), 29 FENCE/ECALL/EBREAK (treated as NOP, rd=0), 31 ILLEGAL (rd=0).
REQ-016 SHALL select operands: R-type/branch data1=rs1, data2=rs2; I-type ALU/load/JALR data1=rs1, data2=immediate; store data1=rs2 (store data), data2=rs1 (base); LUI/AUIPC/JAL data1=data2=0.
REQ-017 SHALL sign-extend I/S immediates to 32 bits; U-type immediate = instr[31:12]<<12; SLLI/SRLI/SRAI immediate = zero-extended shamt; ADDI never maps to SUB.
REQ-018 SHALL set offset to sign-extended B-imm (branches), J-imm (JAL), I-imm (JALR), else 0; ins_addr = pc_in.
REQ-019 SHALL bypass writes: reading rsN with wb_en=1, wb_rd=rsN, rsN!=0 returns wb_data same cycle.
REQ-020 SHALL register all outputs: decoded instruction appears one cycle after acceptance (in_valid & in_ready).
REQ-021 SHALL detect load-use: if the instruction currently in the output register is a load (11-15) with rd!=0 and the incoming instruction uses that register as rs1 or rs2, SHALL drive in_ready=0 and issue a bubble (out_valid=0, optype=0, rd=0) for exactly one cycle, then accept.
REQ-022 SHALL issue a bubble whenever in_valid=0.
REQ-023 SHALL on flush=1: next edge load bubble, discard the presented instruction, cancel any load-use stall; in_ready=1 during flush.
REQ-024 SHALL give priority rst > flush > load-use stall > normal issue.
REQ-025 SHALL perform register-file write regardless of flush or stall.

Reset
REQ-026 SHALL on rst clear all 32 registers and all outputs to 0 (out_valid=0, optype=0); in_ready=1 the cycle after reset deasserts.
REQ-027 SHALL, if rst asserts mid-stall, abandon the stall; no instruction is issued from before reset.

Verification
REQ-028 ADDI x1,x0,-5 (0xFFB00093), pc_in=0x10 -> next cycle out_valid=1, optype=19, data1=0, data2=immediate=0xFFFFFFFB, rd=1, ins_addr=0x10.
REQ-029 wb_en=1 wb_rd=3 wb_data=0x1234 same cycle as ADD x4,x3,x3 -> data1=data2=0x1234, optype=19; wb to x0 then read x0 -> 0.
REQ-030 LW x5,0(x2) then ADD x6,x5,x1 back-to-back -> in_ready=0 one cycle, bubble issued, ADD issued next cycle with rd=6.
REQ-031 flush=1 while stalled on load-use -> next output bubble, in_ready=1, stalled ADD never issued.
REQ-032 BEQ offset -8 (0xFE000CE3) -> optype=5, offset=0xFFFFFFF8, rd=0; JAL x1,+2048 -> optype=3, offset=0x800, rd=1.
REQ-033 undefined opcode 0x0000007F -> optype=31, rd=0, out_valid=1; rst mid-stream -> all outputs 0 next edge.
